// File: rtl/rf_pkg.sv
// rf_pkg: constants and types shared by the register-file write scheduler and its
// result FIFO.
//   RF_DATA_W / RF_ADDR_W         : default data width and register index width
//   RF_NUM_REGS / RF_REG_ZERO     : register count and the hard-wired zero register
//   RF_FIFO_DEPTH / RF_STARVE_LIMIT : default B buffer depth and starvation limit
//   grant_e                       : which requester owns the write port this cycle
package rf_pkg;

  localparam int RF_DATA_W       = 32;
  localparam int RF_ADDR_W       = 5;
  localparam int RF_NUM_REGS     = 32;
  localparam int RF_REG_ZERO     = 0;
  localparam int RF_FIFO_DEPTH   = 2;
  localparam int RF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_result_fifo.sv
// rf_result_fifo: small in-order buffer for long-op (port B) results waiting for the
// register-file write port.
//   clk, rst                  : clock, asynchronous active-high reset (empties the buffer)
//   push_i, push_reg_i/data_i : enqueue one result (caller guarantees !full_o)
//   pop_i                     : dequeue the head (caller guarantees !empty_o)
//   full_o, empty_o           : occupancy flags
//   head_reg_o, head_data_o   : oldest entry, valid while !empty_o
// Push and pop in the same cycle are allowed. DEPTH must be a power of 2 (>= 2) so
// the pointers wrap naturally.
module rf_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_reg_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_reg_o,
  output logic [DATA_W-1:0] head_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] reg_mem [DEPTH];
  logic [DATA_W-1:0] data_mem[DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;

  assign full_o      = (count_q == (PW+1)'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_reg_o  = reg_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      reg_mem[wr_ptr_q]  <= push_reg_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: shares the single register-file write port between the
// pipeline writeback stage (port A, never stalls) and the multi-cycle long-op unit
// (port B, valid/ready through a small FIFO). A busy scoreboard tracks registers whose
// long-latency result is still outstanding and drives decode stalls.
//   clk, rst                    : clock, asynchronous active-high reset
//   a_valid/a_reg/a_data        : writeback request, always accepted unless pipe_stall
//   b_valid/b_ready/b_reg/b_data: long-op result; handshake below
//   iss_valid/iss_reg/iss_ready : long-op issue; marks iss_reg busy when accepted
//   rd_reg1/rd_reg2/rd_stall    : decode sources; stall while either is busy
//   pipe_stall                  : registered, A must be idle the following cycle
//   WB/writeReg/writeData       : registered write to RegisterFile (1 cycle after grant)
//   waw_err                     : sticky, A wrote a register with a pending long op
// Handshake: a B result transfers on a rising edge where b_valid & b_ready are both 1;
// b_ready is 1 exactly when the FIFO is not full and does not depend on b_valid.
module regfile_write_scheduler
  import rf_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int FIFO_DEPTH   = RF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_reg,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic              rd_stall,
  output logic              pipe_stall,
  output logic              WB,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              waw_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = $clog2(STARVE_LIMIT) + 1;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(RF_REG_ZERO);

  logic              fifo_full, fifo_empty, push, pop;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  grant_e            gnt;
  logic              iss_set;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                stall_q, stall_d;
  logic                wb_q, wb_d;
  logic [ADDR_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                waw_q, waw_d;

  rf_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_reg_i (b_reg),
    .push_data_i(b_data),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_reg_o (head_reg),
    .head_data_o(head_data)
  );

  assign b_ready   = ~fifo_full;
  assign push      = b_valid & ~fifo_full;
  assign iss_ready = (iss_reg == ZERO_REG) | ~busy_q[iss_reg];
  assign iss_set   = iss_valid & iss_ready & (iss_reg != ZERO_REG);
  assign rd_stall  = busy_q[rd_reg1] | busy_q[rd_reg2];

  // A wins unless pipe_stall is up; during pipe_stall the B head is forced through.
  always_comb begin
    gnt = GNT_NONE;
    if (a_valid && !stall_q) gnt = GNT_A;
    else if (!fifo_empty)    gnt = GNT_B;
  end
  assign pop = (gnt == GNT_B);

  always_comb begin
    wb_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    waw_d   = waw_q;
    busy_d  = busy_q;
    case (gnt)
      GNT_A: begin
        wb_d    = (a_reg != ZERO_REG);
        wreg_d  = a_reg;
        wdata_d = a_data;
        if (busy_q[a_reg]) waw_d = 1'b1;
      end
      GNT_B: begin
        wb_d    = (head_reg != ZERO_REG);
        wreg_d  = head_reg;
        wdata_d = head_data;
        busy_d[head_reg] = 1'b0;
      end
      default: ;
    endcase
    // Applied after the clear so a same-cycle set of the same register wins.
    if (iss_set) busy_d[iss_reg] = 1'b1;
    busy_d[RF_REG_ZERO] = 1'b0;
  end

  // Count consecutive cycles the B head loses to A; saturates at the threshold.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (fifo_empty || gnt == GNT_B) begin
      starve_d = '0;
    end else if (gnt == GNT_A) begin
      if (starve_q < CNT_W'(STARVE_LIMIT - 1)) starve_d = starve_q + CNT_W'(1);
      stall_d = (starve_q >= CNT_W'(STARVE_LIMIT - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      wb_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      waw_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      wb_q     <= wb_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      waw_q    <= waw_d;
    end
  end

  assign pipe_stall = stall_q;
  assign WB         = wb_q;
  assign writeReg   = wreg_q;
  assign writeData  = wdata_q;
  assign waw_err    = waw_q;

  // The pipeline must hold off A for the cycle after pipe_stall is raised.
  a_no_a_during_stall: assert property (@(posedge clk) disable iff (rst) stall_q |-> !a_valid);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_valid, b_valid, iss_valid;
  logic [AW-1:0] a_reg, b_reg, iss_reg, rd_reg1, rd_reg2;
  logic [DW-1:0] a_data, b_data;
  logic          b_ready, iss_ready, rd_stall, pipe_stall, WB, waw_err;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;

  regfile_write_scheduler #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_stall(rd_stall),
    .pipe_stall(pipe_stall), .WB(WB), .writeReg(writeReg), .writeData(writeData),
    .waw_err(waw_err)
  );

  // scoreboard / reference model
  int n_checks = 0;
  int n_errors = 0;

  logic [AW+DW-1:0] exp_q[$];     // pending B results, {reg, data}, oldest first
  bit               m_busy[32];   // registers with an outstanding long op
  int               m_wait;       // consecutive cycles the oldest B result lost to A
  bit               m_stall;
  bit               m_waw;
  bit               m_wb;
  logic [AW-1:0]    m_reg;
  logic [DW-1:0]    m_data;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wait  = 0;
    m_stall = 1'b0;
    m_waw   = 1'b0;
    m_wb    = 1'b0;
    m_reg   = '0;
    m_data  = '0;
  endtask

  task automatic drive_idle();
    a_valid = 0; a_reg = '0; a_data = '0;
    b_valid = 0; b_reg = '0; b_data = '0;
    iss_valid = 0; iss_reg = '0;
    rd_reg1 = '0; rd_reg2 = '0;
  endtask

  // Called at a falling edge; asserts reset, checks the cleared state, releases.
  task automatic apply_reset(input logic [AW-1:0] probe_reg);
    drive_idle();
    rd_reg1 = probe_reg;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_wb", WB, 0);
    check("rst_wreg", writeReg, 0);
    check("rst_wdata", writeData, 0);
    check("rst_pipe_stall", pipe_stall, 0);
    check("rst_waw", waw_err, 0);
    check("rst_b_ready", b_ready, 1);
    check("rst_rd_stall", rd_stall, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs, let the
  // rising edge happen, advance the model, then check registered outputs.
  task automatic step(input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input bit bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                      input bit iv, input logic [AW-1:0] ir,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit               e_b_ready, e_iss_ready, e_rd_stall;
    bit               nonempty, take_a, take_b, accepted;
    int               wait_before;
    logic [AW+DW-1:0] head;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    iss_valid = iss_valid; iss_valid = iv; iss_reg = ir;
    rd_reg1 = r1; rd_reg2 = r2;

    e_b_ready   = (exp_q.size() < DEPTH);
    e_iss_ready = (ir == 0) || !m_busy[ir];
    e_rd_stall  = m_busy[r1] || m_busy[r2];
    #1;
    check("b_ready", b_ready, e_b_ready);
    check("iss_ready", iss_ready, e_iss_ready);
    check("rd_stall", rd_stall, e_rd_stall);

    @(posedge clk);
    nonempty    = (exp_q.size() != 0);
    wait_before = m_wait;
    accepted    = bv && e_b_ready;
    take_a      = av && !m_stall;
    take_b      = !take_a && nonempty;
    m_wb        = 1'b0;
    if (take_a) begin
      m_reg  = ar;
      m_data = ad;
      m_wb   = (ar != 0);
      if (m_busy[ar]) m_waw = 1'b1;
    end else if (take_b) begin
      head   = exp_q.pop_front();
      m_reg  = head[AW+DW-1:DW];
      m_data = head[DW-1:0];
      m_wb   = (m_reg != 0);
      m_busy[m_reg] = 1'b0;
    end
    if (iv && e_iss_ready && ir != 0) m_busy[ir] = 1'b1;
    if (accepted) exp_q.push_back({br, bd});
    // The oldest B result has now lost to A for (wait_before + 1) cycles in a row.
    m_stall = take_a && nonempty && (wait_before + 1 >= LIMIT);
    if (!nonempty || take_b) m_wait = 0;
    else if (take_a)         m_wait = wait_before + 1;

    #1;
    check("wb", WB, m_wb);
    if (m_wb) begin
      check("write_reg", writeReg, m_reg);
      check("write_data", writeData, m_data);
    end
    check("pipe_stall", pipe_stall, m_stall);
    check("waw_err", waw_err, m_waw);
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] r1);
    step(0, '0, '0, 0, '0, '0, 0, '0, r1, '0);
  endtask

  initial begin
    drive_idle();
    model_reset();
    apply_reset('0);

    // plain A write, then idle
    step(1, 5'd5, 32'h11, 0, '0, '0, 0, '0, '0, '0);
    check("t1_wb", WB, 1);
    check("t1_reg", writeReg, 5);
    check("t1_data", writeData, 32'h11);
    idle('0);
    check("t1_idle_wb", WB, 0);

    // issue to r8, decode stalls on r8 until the B result for r8 is written
    step(0, '0, '0, 0, '0, '0, 1, 5'd8, '0, '0);
    idle(5'd8);
    check("t2_stall", rd_stall, 1);
    step(0, '0, '0, 1, 5'd8, 32'h80, 0, '0, 5'd8, '0);
    idle(5'd8);
    check("t2_wb", WB, 1);
    check("t2_reg", writeReg, 8);
    check("t2_data", writeData, 32'h80);
    check("t2_cleared", rd_stall, 0);

    // A and B together on an empty FIFO: A first, B one cycle later
    step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, '0, '0, '0);
    check("t3_a_reg", writeReg, 3);
    idle('0);
    check("t3_b_wb", WB, 1);
    check("t3_b_reg", writeReg, 4);
    check("t3_b_data", writeData, 32'h44);

    // fill the FIFO while A streams, starvation raises pipe_stall, then B drains
    for (int i = 0; i < 5; i++) begin
      step(1, AW'(20 + i), DW'(32'hA0 + i), (i < 3), AW'(10 + i), DW'(32'hB0 + i),
           0, '0, '0, '0);
      if (i == 1) check("t4_full", b_ready, 0);
    end
    check("t4_pipe_stall", pipe_stall, 1);
    idle('0);
    check("t4_b_first", writeReg, 10);
    idle('0);
    check("t4_b_second", writeReg, 11);
    idle('0);
    check("t4_drained_wb", WB, 0);

    // double issue to r8 is refused, then A writes r8 -> sticky WAW
    step(0, '0, '0, 0, '0, '0, 1, 5'd8, '0, '0);
    check("t5_iss_ready", iss_ready, 0);
    step(0, '0, '0, 0, '0, '0, 1, 5'd8, '0, '0);
    step(1, 5'd8, 32'h88, 0, '0, '0, 0, '0, '0, '0);
    check("t5_waw", waw_err, 1);
    check("t5_wb", WB, 1);
    idle('0);
    check("t5_waw_sticky", waw_err, 1);

    // register 0 is never written and never marked busy
    step(1, 5'd0, 32'h99, 1, 5'd0, 32'h77, 1, 5'd0, '0, '0);
    check("t6_a0_wb", WB, 0);
    idle('0);
    check("t6_b0_wb", WB, 0);

    // randomized traffic on a small register range to force collisions
    for (int i = 0; i < 400; i++) begin
      step(!m_stall && ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 4), AW'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 3), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    // drain, then reset with two results buffered and a busy register
    for (int i = 0; i < 8; i++) idle('0);
    check("t7_empty", b_ready, 1);
    step(0, '0, '0, 0, '0, '0, 1, 5'd9, '0, '0);
    step(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, '0, '0, '0);
    step(1, 5'd1, 32'h1, 1, 5'd3, 32'h3, 0, '0, 5'd9, '0);
    check("t7_full", b_ready, 0);
    check("t7_busy9", rd_stall, 1);
    apply_reset(5'd9);
    for (int i = 0; i < 3; i++) begin
      idle(5'd9);
      check("t7_no_write", WB, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
